// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam logic ARB_RR    = 1'b0;
  localparam logic ARB_FIXED = 1'b1;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } mem_req_t;

  // A read never drives byte lanes, so its mask is cleared when latched.
  function automatic mem_req_t make_req(input logic we, input logic [31:0] addr,
                                        input logic [3:0] mask, input logic [31:0] data);
    mem_req_t r;
    r.we   = we;
    r.addr = addr;
    r.mask = we ? mask : 4'h0;
    r.data = data;
    return r;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational 2-way winner select; produces a one-hot grant from the request pair.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       mode_i,
  output logic [1:0] grant_o
);

  // Tie goes to m0 in fixed mode, otherwise to whichever master was not served last.
  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01: grant_o = 2'b01;
      2'b10: grant_o = 2'b10;
      2'b11: begin
        if ((mode_i == ARB_FIXED) || (last_i == M1)) begin
          grant_o = 2'b01;
        end else begin
          grant_o = 2'b10;
        end
      end
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one 32-bit memory port between two req/ack masters; latches the winner's
// request, drives memory for a fixed access time and returns a one-cycle ack.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int ARB_MODE   = 0
) (
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [3:0]  m0_wr_mask_i,
  input  logic [31:0] m0_data_i,
  output logic        m0_ack_o,
  output logic [31:0] m0_data_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [3:0]  m1_wr_mask_i,
  input  logic [31:0] m1_data_i,
  output logic        m1_ack_o,
  output logic [31:0] m1_data_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_wr_mask_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  output logic [1:0]  grant_o,
  output logic        busy_o
);

  localparam logic [3:0] RD_LAT_C = RD_LATENCY[3:0];
  localparam logic       MODE_C   = (ARB_MODE == 0) ? ARB_RR : ARB_FIXED;

  arb_state_e  state_q, state_d;
  mem_req_t    req_q, req_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic [1:0]  grant_q, grant_d;
  logic        busy_q, busy_d;
  logic        mem_we_q, mem_we_d;
  logic [1:0]  ack_q, ack_d;
  logic [31:0] m0_data_q, m0_data_d;
  logic [31:0] m1_data_q, m1_data_d;
  logic [1:0]  win_s;

  mem_arb_pick u_pick (
    .req_i   ({m1_req_i, m0_req_i}),
    .last_i  (last_q),
    .mode_i  (MODE_C),
    .grant_o (win_s)
  );

  // Next-state and next-output computation for the IDLE -> ACCESS -> DONE sequence.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    mem_we_d  = 1'b0;
    ack_d     = 2'b00;
    m0_data_d = 32'h0;
    m1_data_d = 32'h0;
    case (state_q)
      ST_IDLE: begin
        if (win_s != 2'b00) begin
          if (win_s[1]) begin
            req_d = make_req(m1_we_i, m1_addr_i, m1_wr_mask_i, m1_data_i);
          end else begin
            req_d = make_req(m0_we_i, m0_addr_i, m0_wr_mask_i, m0_data_i);
          end
          mem_we_d = req_d.we;
          grant_d  = win_s;
          busy_d   = 1'b1;
          cnt_d    = 4'd0;
          state_d  = ST_ACCESS;
        end else begin
          grant_d = 2'b00;
          busy_d  = 1'b0;
        end
      end
      ST_ACCESS: begin
        if (req_q.we) begin
          ack_d   = grant_q;
          state_d = ST_DONE;
        end else if (cnt_q == RD_LAT_C) begin
          // Read data is valid in this cycle; it is handed straight to the owner's data flop.
          ack_d = grant_q;
          if (grant_q[1]) begin
            m1_data_d = mem_data_i;
          end else begin
            m0_data_d = mem_data_i;
          end
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DONE: begin
        last_d  = grant_q[1];
        grant_d = 2'b00;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = 2'b00;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; last-grant resets to m1 so m0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      cnt_q     <= 4'd0;
      last_q    <= M1;
      grant_q   <= 2'b00;
      busy_q    <= 1'b0;
      mem_we_q  <= 1'b0;
      ack_q     <= 2'b00;
      m0_data_q <= 32'h0;
      m1_data_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      mem_we_q  <= mem_we_d;
      ack_q     <= ack_d;
      m0_data_q <= m0_data_d;
      m1_data_q <= m1_data_d;
    end
  end

  assign mem_addr_o    = req_q.addr;
  assign mem_wr_mask_o = req_q.mask;
  assign mem_data_o    = req_q.data;
  assign mem_we_o      = mem_we_q;
  assign grant_o       = grant_q;
  assign busy_o        = busy_q;
  assign m0_ack_o      = ack_q[0];
  assign m1_ack_o      = ack_q[1];
  assign m0_data_o     = m0_data_q;
  assign m1_data_o     = m1_data_q;

endmodule
